simplified_fp_gt: RTL and testbench
===================================

# simplified_fp_gt

Registered greater-than comparator for the team's 13-bit simplified floating-point format: 1 sign bit, 4-bit unsigned exponent, 8-bit normalized fraction. The value is (-1)^s × 0.f × 2^e. The block answers "a > b" with one cycle of latency. It sits in the datapath next to the simplified FP adder and feeds sorting, max/min, and threshold logic.

## Interface
Parameters:
- EXP_W, 4, exponent width
- FRAC_W, 8, fraction width; word width W = 1+EXP_W+FRAC_W (13)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- in_valid  input  1  operands on a/b are valid this cycle
- a  input  W  operand A: [W-1] sign, [W-2:FRAC_W] exponent, [FRAC_W-1:0] fraction
- b  input  W  operand B, same layout
- gt  output  1  registered result: 1 when value(a) > value(b)
- out_valid  output  1  registered; gt corresponds to operands sampled in the previous cycle

## Operation
- Field split: sign s, exponent e, fraction f. Magnitude key k = {e,f}, an unsigned (W-1)-bit value.
- Zero: an operand is zero when f == 0, whatever e or s. The key of a zero operand is forced to 0. +0 and -0 are equal.
- Normalized nonzero operands have f[MSB] = 1, so key order equals magnitude order. Unnormalized nonzero operands are still compared by raw key. That result is deterministic but not value-exact.
- Decision, with za/zb as the zero flags:
  - both zero -> gt = 0
  - sa != sb -> gt = ~sa (a positive, b negative)
  - sa = sb = 0 -> gt = (ka > kb)
  - sa = sb = 1 -> gt = (ka < kb)
- Equal operands always give gt = 0.
- There is no NaN/infinity encoding. Every bit pattern is a finite number.

## Timing
- Reset asserted, asynchronously: gt = 0, out_valid = 0. Both hold while reset is high.
- Each rising clk edge, outside reset:
  - out_valid <= in_valid.
  - gt <= compare(a, b) when in_valid = 1.
  - gt holds its previous value when in_valid = 0.
- Latency is exactly 1 cycle. Throughput is one comparison per cycle with back-to-back in_valid.
- No backpressure and no stall input.
- Reset mid-stream drops any in-flight result. The first valid result after reset release comes one cycle after the first in_valid sampled out of reset.
- The compare path from a/b to the gt D-input is purely combinational. a and b need only be stable at the sampling edge.

## Structure
- Shared package simplified_fp_pkg:
  - EXP_W, FRAC_W, W constants
  - field-extract functions fp_sign, fp_exp, fp_frac
  - is_zero function, reused by the simplified FP adder and converters
- One natural sub-module: fp_mag_cmp, a combinational unsigned key comparator producing k_gt and k_lt.
- The top level adds zero/sign steering and the output registers.

## Test plan
- Reset: hold reset with in_valid = 1 and random operands -> gt = 0, out_valid = 0 throughout. After release, the first result appears one cycle after the first sampled in_valid.
- Same exponent, sign combinations, with a = 0x0AAA-class +0.68E3 (0_1010_10101010) and b = +0.86E3 (0_1010_11010111):
  - (+a,+b) -> 0; (-a,+b) -> 0; (+a,-b) -> 1; (-a,-b) -> 1
  - with a and b swapped: 1, 0, 1, 0
- Exponent dominates:
  - a = +0.68E4 (0_1101_11010100) vs b = ±0.86E3 -> 1/1; with a negative -> 0/0
  - a = ±0.68E3 vs b = +0.86E4 (0_1110_10000110) -> 0; vs -0.86E4 -> 1
- Exponent zero: +0.68E0 (0_0000_10101110) vs +0.86E0 (0_0000_11011100) -> 0; vs -0.86E0 -> 1.
- Equality and zero:
  - ±0.68E0 vs the identical value -> 0
  - +0 vs +0 -> 0; +0 vs -0 -> 0; -0 vs +0 -> 0
  - 0_0101_00000000 vs -0 -> 0
- Streaming: back-to-back in_valid over 20 random normalized pairs, with an in_valid gap mid-stream -> each gt matches the golden model one cycle later, out_valid tracks in_valid delayed by 1, and gt holds during the gap.

Source files
------------

// File: rtl/simplified_fp_pkg.sv
// Shared definitions for the 13-bit simplified floating-point format:
// 1 sign bit, 4-bit unsigned exponent, 8-bit normalized fraction.
package simplified_fp_pkg;

   localparam int unsigned EXP_W  = 4;
   localparam int unsigned FRAC_W = 8;
   localparam int unsigned W      = 1 + EXP_W + FRAC_W;
   localparam int unsigned KEY_W  = EXP_W + FRAC_W;

   typedef logic [W-1:0]      fp_t;
   typedef logic [EXP_W-1:0]  exp_t;
   typedef logic [FRAC_W-1:0] frac_t;
   typedef logic [KEY_W-1:0]  key_t;

   function automatic logic fp_sign(input fp_t x);
      return x[W-1];
   endfunction

   function automatic exp_t fp_exp(input fp_t x);
      return x[W-2:FRAC_W];
   endfunction

   function automatic frac_t fp_frac(input fp_t x);
      return x[FRAC_W-1:0];
   endfunction

   // A zero fraction means zero, whatever the exponent or sign.
   function automatic logic is_zero(input fp_t x);
      return fp_frac(x) == '0;
   endfunction

   // Magnitude key {exp, frac}; zeros collapse to 0 so +0 == -0.
   function automatic key_t fp_key(input fp_t x);
      return is_zero(x) ? '0 : {fp_exp(x), fp_frac(x)};
   endfunction

endpackage

// File: rtl/simplified_fp_gt_if.sv
// Operand/result bundle for the simplified FP greater-than comparator.
interface simplified_fp_gt_if #(
   parameter int unsigned W = simplified_fp_pkg::W
);
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         gt;
   logic         out_valid;

   modport master (output in_valid, a, b, input gt, out_valid);
   modport slave  (input in_valid, a, b, output gt, out_valid);
endinterface

// File: rtl/simplified_fp_gt_mag_cmp.sv
// Combinational unsigned magnitude-key comparator.
module fp_mag_cmp #(
   parameter int unsigned KEY_W = simplified_fp_pkg::KEY_W
) (
   input  logic [KEY_W-1:0] ka,
   input  logic [KEY_W-1:0] kb,
   output logic             k_gt,
   output logic             k_lt
);

   // Plain unsigned ordering of the two keys.
   always_comb begin
      k_gt = (ka > kb);
      k_lt = (ka < kb);
   end

endmodule

// File: rtl/simplified_fp_gt.sv
// Registered "a > b" for the simplified FP format, one cycle of latency.
module simplified_fp_gt #(
   parameter int unsigned EXP_W  = simplified_fp_pkg::EXP_W,
   parameter int unsigned FRAC_W = simplified_fp_pkg::FRAC_W
) (
   input  logic             clk,
   input  logic             reset,
   simplified_fp_gt_if.slave bus
);
   import simplified_fp_pkg::*;

   localparam int unsigned MAG_W = EXP_W + FRAC_W;

   logic             za, zb, sa, sb;
   logic [MAG_W-1:0] ka, kb;
   logic             k_gt, k_lt;
   logic             gt_d;

   // Field split with zero operands forced to key 0.
   always_comb begin
      za = is_zero(bus.a);
      zb = is_zero(bus.b);
      sa = fp_sign(bus.a);
      sb = fp_sign(bus.b);
      ka = fp_key(bus.a);
      kb = fp_key(bus.b);
   end

   fp_mag_cmp #(.KEY_W(MAG_W)) u_mag_cmp (
      .ka   (ka),
      .kb   (kb),
      .k_gt (k_gt),
      .k_lt (k_lt)
   );

   // Sign steering: a signed zero against a nonzero of the opposite sign is
   // still ordered correctly by the sign test, so only both-zero is special.
   always_comb begin
      gt_d = 1'b0;
      if (za && zb)
         gt_d = 1'b0;
      else if (sa != sb)
         gt_d = ~sa;
      else if (!sa)
         gt_d = k_gt;
      else
         gt_d = k_lt;
   end

   // Output registers; gt holds while no new operands arrive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.gt        <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid)
            bus.gt <= gt_d;
      end
   end

endmodule

// File: tb/tb_simplified_fp_gt.sv
// Directed and streaming checks for simplified_fp_gt.
module tb_simplified_fp_gt;

   logic clk;
   logic reset;
   int   nvec;
   int   nerr;

   simplified_fp_gt_if #(.W(13)) bus ();

   simplified_fp_gt #(.EXP_W(4), .FRAC_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] a;
      logic [12:0] b;
      logic        gt;
      string       name;
   } vec_t;

   vec_t vt[27];

   // Independent reference: map each word to a signed integer value.
   function automatic logic model_gt(input logic [12:0] x, input logic [12:0] y);
      int vx, vy;
      vx = (x[7:0] == 8'h00) ? 0 : int'(x[11:0]);
      vy = (y[7:0] == 8'h00) ? 0 : int'(y[11:0]);
      if (x[12]) vx = -vx;
      if (y[12]) vy = -vy;
      return vx > vy;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive at the falling edge, return 1 ns after the next rising edge.
   task automatic apply(input logic iv, input logic [12:0] a, input logic [12:0] b);
      @(negedge clk);
      bus.in_valid = iv;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic        exp_gt;
      logic [12:0] ra, rb;

      nvec = 0;
      nerr = 0;

      vt[0]  = '{13'h0AAA, 13'h0AD7, 1'b0, "same_exp +a +b"};
      vt[1]  = '{13'h1AAA, 13'h0AD7, 1'b0, "same_exp -a +b"};
      vt[2]  = '{13'h0AAA, 13'h1AD7, 1'b1, "same_exp +a -b"};
      vt[3]  = '{13'h1AAA, 13'h1AD7, 1'b1, "same_exp -a -b"};
      vt[4]  = '{13'h0AD7, 13'h0AAA, 1'b1, "swap +b +a"};
      vt[5]  = '{13'h1AD7, 13'h0AAA, 1'b0, "swap -b +a"};
      vt[6]  = '{13'h0AD7, 13'h1AAA, 1'b1, "swap +b -a"};
      vt[7]  = '{13'h1AD7, 13'h1AAA, 1'b0, "swap -b -a"};
      vt[8]  = '{13'h0DD4, 13'h0AD7, 1'b1, "exp_dom +c +b"};
      vt[9]  = '{13'h0DD4, 13'h1AD7, 1'b1, "exp_dom +c -b"};
      vt[10] = '{13'h1DD4, 13'h0AD7, 1'b0, "exp_dom -c +b"};
      vt[11] = '{13'h1DD4, 13'h1AD7, 1'b0, "exp_dom -c -b"};
      vt[12] = '{13'h0AAA, 13'h0E86, 1'b0, "exp_dom +a +d"};
      vt[13] = '{13'h1AAA, 13'h0E86, 1'b0, "exp_dom -a +d"};
      vt[14] = '{13'h0AAA, 13'h1E86, 1'b1, "exp_dom +a -d"};
      vt[15] = '{13'h1AAA, 13'h1E86, 1'b1, "exp_dom -a -d"};
      vt[16] = '{13'h00AE, 13'h00DC, 1'b0, "exp0 +e +f"};
      vt[17] = '{13'h00AE, 13'h10DC, 1'b1, "exp0 +e -f"};
      vt[18] = '{13'h00AE, 13'h00AE, 1'b0, "equal +e"};
      vt[19] = '{13'h10AE, 13'h10AE, 1'b0, "equal -e"};
      vt[20] = '{13'h0000, 13'h0000, 1'b0, "zero +0 +0"};
      vt[21] = '{13'h0000, 13'h1000, 1'b0, "zero +0 -0"};
      vt[22] = '{13'h1000, 13'h0000, 1'b0, "zero -0 +0"};
      vt[23] = '{13'h0500, 13'h1000, 1'b0, "zero exp5 -0"};
      vt[24] = '{13'h1AAA, 13'h1000, 1'b0, "zero -a -0"};
      vt[25] = '{13'h0AAA, 13'h1000, 1'b1, "zero +a -0"};
      vt[26] = '{13'h1000, 13'h1AAA, 1'b1, "zero -0 -a"};

      // Reset held with valid operands presented: outputs stay low.
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 13'h0AAA;
      bus.b        = 13'h1AD7;
      #1;
      check("reset gt", bus.gt, 1'b0);
      check("reset out_valid", bus.out_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 13'($urandom), 13'($urandom));
         check("reset_hold gt", bus.gt, 1'b0);
         check("reset_hold out_valid", bus.out_valid, 1'b0);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset idle out_valid", bus.out_valid, 1'b0);
      check("post_reset idle gt", bus.gt, 1'b0);
      apply(1'b1, 13'h0AAA, 13'h1AD7);
      check("first_result gt", bus.gt, 1'b1);
      check("first_result out_valid", bus.out_valid, 1'b1);

      // Directed table.
      for (int i = 0; i < 27; i++) begin
         apply(1'b1, vt[i].a, vt[i].b);
         check(vt[i].name, bus.gt, vt[i].gt);
         check({vt[i].name, " out_valid"}, bus.out_valid, 1'b1);
      end

      // Streaming with a three-cycle gap after the tenth pair.
      exp_gt = bus.gt;
      for (int i = 0; i < 23; i++) begin
         logic iv;
         iv = !(i >= 10 && i < 13);
         ra = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, 7'($urandom)};
         rb = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, 7'($urandom)};
         if (iv)
            exp_gt = model_gt(ra, rb);
         apply(iv, ra, rb);
         check("stream gt", bus.gt, exp_gt);
         check("stream out_valid", bus.out_valid, iv);
      end

      // Asynchronous reset mid-stream drops the in-flight result.
      apply(1'b1, 13'h0AAA, 13'h1AD7);
      check("pre_abort gt", bus.gt, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 13'h0DD4;
      bus.b        = 13'h0AD7;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset gt", bus.gt, 1'b0);
      check("async_reset out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
      check("abort_hold out_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_idle out_valid", bus.out_valid, 1'b0);
      check("abort_idle gt", bus.gt, 1'b0);
      apply(1'b1, 13'h0DD4, 13'h0AD7);
      check("abort_first gt", bus.gt, 1'b1);
      check("abort_first out_valid", bus.out_valid, 1'b1);
      apply(1'b0, 13'h0000, 13'h0000);
      check("tail hold gt", bus.gt, 1'b1);
      check("tail out_valid", bus.out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
